// File: rtl/cpack_ts_sync_fifo.sv
// Sync-aligned FWFT FIFO between the timestamping channel packer and the DMA AXI-Stream slave.
// Optional build macro CPACK_TS_FIFO_DROP_COUNT_EN adds a saturating drop_count output.
module cpack_ts_sync_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  capture_en,
    input  logic                  fifo_wr_en,
    input  logic                  fifo_wr_sync,
    input  logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_wr_overflow,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_user,
    output logic [ADDR_WIDTH:0]   level,
`ifdef CPACK_TS_FIFO_DROP_COUNT_EN
    output logic [31:0]           drop_count,
`endif
    output logic [1:0]            state_dbg
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_STREAM    = 2'd2,
        ST_DROP      = 2'd3
    } state_t;

    // m_axis handshake: a word transfers on any cycle with valid && ready;
    // valid never depends on ready, and head data/user hold while valid && !ready.

    state_t                state_q;
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  overflow_q;
    logic [DATA_WIDTH:0]   mem_q [DEPTH];

    logic [ADDR_WIDTH:0]   count;
    logic                  empty, full, pop, space;
    logic                  permit, accept, discard, flush;
    logic [DATA_WIDTH:0]   head;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign full  = (count == DEPTH_W);
    assign pop   = !empty && m_axis_ready;
    assign space = !full || pop;

    always_comb begin
        permit = 1'b0;
        case (state_q)
            ST_IDLE:      permit = 1'b0;
            ST_WAIT_SYNC: permit = fifo_wr_sync;
            ST_STREAM:    permit = 1'b1;
            ST_DROP:      permit = fifo_wr_sync;
            default:      permit = 1'b0;
        endcase
    end

    assign accept  = fifo_wr_en && permit && space;
    assign discard = fifo_wr_en && !accept;
    // Leaving for IDLE flushes on the same edge so valid drops one cycle after capture_en falls.
    assign flush   = (state_q == ST_IDLE) || !capture_en;

    assign wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, accept};
    assign rd_ptr_d = flush ? wr_ptr_d : rd_ptr_q + {{ADDR_WIDTH{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= (state_q == ST_STREAM) && discard;
            if (!capture_en && state_q != ST_IDLE) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE:      if (capture_en) state_q <= ST_WAIT_SYNC;
                    ST_WAIT_SYNC: if (accept) state_q <= ST_STREAM;
                    ST_STREAM:    if (discard) state_q <= ST_DROP;
                    ST_DROP:      if (accept) state_q <= ST_STREAM;
                    default:      state_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {fifo_wr_sync, fifo_wr_data};
        end
    end

    assign head             = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign m_axis_valid     = !empty;
    assign m_axis_data      = head[DATA_WIDTH-1:0];
    assign m_axis_user      = !empty && head[DATA_WIDTH];
    assign level            = count;
    assign fifo_wr_overflow = overflow_q;
    assign state_dbg        = state_q;

`ifdef CPACK_TS_FIFO_DROP_COUNT_EN
    logic [31:0] drop_cnt_q;

    // Only losses after capture has locked onto a sync word are counted.
    always_ff @(posedge clk) begin
        if (reset || (state_q == ST_IDLE && capture_en)) begin
            drop_cnt_q <= '0;
        end else if (discard && (state_q == ST_STREAM || state_q == ST_DROP)
                     && drop_cnt_q != 32'hFFFF_FFFF) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cpack_ts_sync_fifo.sv
// Directed bench for cpack_ts_sync_fifo: sync alignment, overflow/resync, full push+pop, disable and reset.
module tb_cpack_ts_sync_fifo;

    localparam int DW = 128;
    localparam int AW = 4;
    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_STREAM = 2'd2, S_DROP = 2'd3;

    logic          clk = 1'b0;
    logic          reset, capture_en, wr_en, wr_sync, ready;
    logic [DW-1:0] wr_data;
    logic          fifo_wr_overflow, m_axis_valid, m_axis_user;
    logic [DW-1:0] m_axis_data;
    logic [AW:0]   level;
    logic [1:0]    state_dbg;
`ifdef CPACK_TS_FIFO_DROP_COUNT_EN
    logic [31:0]   drop_count;
`endif

    cpack_ts_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .capture_en       (capture_en),
        .fifo_wr_en       (wr_en),
        .fifo_wr_sync     (wr_sync),
        .fifo_wr_data     (wr_data),
        .fifo_wr_overflow (fifo_wr_overflow),
        .m_axis_valid     (m_axis_valid),
        .m_axis_ready     (ready),
        .m_axis_data      (m_axis_data),
        .m_axis_user      (m_axis_user),
        .level            (level),
`ifdef CPACK_TS_FIFO_DROP_COUNT_EN
        .drop_count       (drop_count),
`endif
        .state_dbg        (state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ovf_cnt = 0;
    logic [DW:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe the handshake mid-cycle, then return 1ns after the next rising edge.
    task automatic tick();
        #2;
        if (fifo_wr_overflow) ovf_cnt++;
        if (m_axis_valid && ready) begin
            if (exp_q.size() == 0)
                check_eq("pop_unexpected", (DW+1)'(exp_q.size()), (DW+1)'(1));
            else
                check_eq("pop_word", {m_axis_user, m_axis_data}, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic s, input bit keep);
        wr_en   = 1'b1;
        wr_sync = s;
        wr_data = d;
        if (keep) exp_q.push_back({s, d});
        tick();
        wr_en   = 1'b0;
        wr_sync = 1'b0;
    endtask

    task automatic check_level(input string tag, input int exp);
        check_eq(tag, (DW+1)'(level), (DW+1)'(exp));
    endtask

    task automatic check_state(input string tag, input logic [1:0] exp);
        check_eq(tag, (DW+1)'(state_dbg), (DW+1)'(exp));
    endtask

    initial begin
        reset = 1'b1; capture_en = 1'b0; wr_en = 1'b0; wr_sync = 1'b0;
        wr_data = '0; ready = 1'b0;
        @(posedge clk); #1;
        repeat (3) tick();
        reset = 1'b0;
        check_eq("rst_valid", (DW+1)'(m_axis_valid), '0);
        check_eq("rst_ovf", (DW+1)'(fifo_wr_overflow), '0);
        check_eq("rst_user", (DW+1)'(m_axis_user), '0);
        check_level("rst_level", 0);
        check_state("rst_state", S_IDLE);

        // 1: capture starts on the first sync word
        capture_en = 1'b1;
        tick();
        check_state("t1_wait", S_WAIT);
        ready = 1'b1;
        for (int i = 0; i < 3; i++) push(DW'(32'hD000_0000 + i), 1'b0, 1'b0);
        check_level("t1_skip_level", 0);
        check_state("t1_still_wait", S_WAIT);
        push(DW'(32'hD000_0003), 1'b1, 1'b1);
        check_state("t1_stream", S_STREAM);
        check_level("t1_level1", 1);
        check_eq("t1_head", {m_axis_user, m_axis_data}, {1'b1, DW'(32'hD000_0003)});
        push(DW'(32'hD000_0004), 1'b0, 1'b1);
        tick(); tick();
        check_level("t1_drained", 0);
        check_eq("t1_sb_empty", (DW+1)'(exp_q.size()), '0);
        check_eq("t1_no_ovf", (DW+1)'(ovf_cnt), '0);

        // 2: backpressure fill, 17th write overflows
        ready = 1'b0;
        push(DW'(32'hB000_0000), 1'b1, 1'b1);
        for (int i = 1; i < 16; i++) push(DW'(32'hB000_0000 + i), 1'b0, 1'b1);
        check_level("t2_full", 16);
        check_state("t2_stream", S_STREAM);
        check_eq("t2_ovf_low", (DW+1)'(fifo_wr_overflow), '0);
        push(DW'(32'hB000_0010), 1'b0, 1'b0);
        check_eq("t2_ovf_pulse", (DW+1)'(fifo_wr_overflow), (DW+1)'(1));
        check_state("t2_drop", S_DROP);
        check_level("t2_full_after", 16);
        tick();
        check_eq("t2_ovf_end", (DW+1)'(fifo_wr_overflow), '0);

        // 3: drain in order, non-sync writes discarded, resync on sync word
        ready = 1'b1;
        for (int i = 0; i < 16; i++) push(DW'(32'hC000_0000 + i), 1'b0, 1'b0);
        check_level("t3_drained", 0);
        check_state("t3_still_drop", S_DROP);
        check_eq("t3_sb_empty", (DW+1)'(exp_q.size()), '0);
        push(DW'(32'hE000_0001), 1'b1, 1'b1);
        check_state("t3_resync", S_STREAM);
        check_level("t3_level1", 1);
        check_eq("t3_head", {m_axis_user, m_axis_data}, {1'b1, DW'(32'hE000_0001)});
        tick();
        check_level("t3_empty", 0);
        check_eq("t3_one_ovf", (DW+1)'(ovf_cnt), (DW+1)'(1));
`ifdef CPACK_TS_FIFO_DROP_COUNT_EN
        check_eq("t3_drop_count", (DW+1)'(drop_count), (DW+1)'(17));
`endif

        // 4: simultaneous push and pop when full
        ready = 1'b0;
        push(DW'(32'hF000_0000), 1'b1, 1'b1);
        for (int i = 1; i < 16; i++) push(DW'(32'hF000_0000 + i), 1'b0, 1'b1);
        check_level("t4_full", 16);
        ready = 1'b1;
        push(DW'(32'hF000_0010), 1'b0, 1'b1);
        check_level("t4_level_kept", 16);
        check_eq("t4_no_ovf", (DW+1)'(fifo_wr_overflow), '0);
        check_state("t4_stream", S_STREAM);
        for (int i = 0; i < 16; i++) tick();
        check_level("t4_drained", 0);
        check_eq("t4_sb_empty", (DW+1)'(exp_q.size()), '0);
        check_eq("t4_ovf_total", (DW+1)'(ovf_cnt), (DW+1)'(1));

        // 5: mid-stream disable flushes, re-enable waits for sync
        ready = 1'b0;
        push(DW'(32'h5000_0000), 1'b1, 1'b1);
        for (int i = 1; i < 5; i++) push(DW'(32'h5000_0000 + i), 1'b0, 1'b1);
        check_level("t5_level5", 5);
        capture_en = 1'b0;
        tick();
        exp_q.delete();
        check_eq("t5_valid_off", (DW+1)'(m_axis_valid), '0);
        check_level("t5_flushed", 0);
        check_state("t5_idle", S_IDLE);
        capture_en = 1'b1;
        tick();
        check_state("t5_rearm", S_WAIT);
        push(DW'(32'h5000_0010), 1'b0, 1'b0);
        check_level("t5_nosync_drop", 0);
        check_state("t5_wait", S_WAIT);
        push(DW'(32'h5000_0011), 1'b1, 1'b1);
        check_level("t5_sync_in", 1);
        check_eq("t5_head", {m_axis_user, m_axis_data}, {1'b1, DW'(32'h5000_0011)});
        ready = 1'b1;
        tick();
        check_level("t5_empty", 0);

        // 6: synchronous reset with 8 words buffered
        ready = 1'b0;
        for (int i = 0; i < 8; i++) push(DW'(32'h6000_0000 + i), (i == 0), 1'b1);
        check_level("t6_level8", 8);
        reset = 1'b1;
        tick();
        exp_q.delete();
        check_eq("t6_valid", (DW+1)'(m_axis_valid), '0);
        check_eq("t6_user", (DW+1)'(m_axis_user), '0);
        check_level("t6_level", 0);
        check_state("t6_idle", S_IDLE);
`ifdef CPACK_TS_FIFO_DROP_COUNT_EN
        check_eq("t6_drop_count", (DW+1)'(drop_count), '0);
`endif
        reset = 1'b0;
        capture_en = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpack_ts_sync_fifo.md
Name: cpack_ts_sync_fifo

Overview:
Downstream stage of the timestamping channel packer; consumes its packed write strobe/sync/data and buffers words in a small FIFO toward the DMA AXI-Stream slave.
- Gates the stream so that capture always begins on a sync-flagged word, i.e. a timestamp word when timestamping is enabled.
- On overflow it drops data and re-aligns on the next sync, so software never receives a stream that starts mid-block.
- Reports overflow back to the packer.

Parameters:
DATA_WIDTH, 128, width of one packed word (2*4 channels*16 bit).
ADDR_WIDTH, 4, FIFO depth = 2**ADDR_WIDTH words; minimum 2.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
capture_en  input  1  level; 1 = arm/run capture, 0 = idle and flush.
fifo_wr_en  input  1  packer write strobe; one word per asserted cycle.
fifo_wr_sync  input  1  qualifies fifo_wr_en; word is a block/timestamp boundary.
fifo_wr_data  input  DATA_WIDTH  packed word.
fifo_wr_overflow  output  1  one-cycle pulse per overflow event, to packer.
m_axis_valid  output  1  FIFO non-empty.
m_axis_ready  input  1  DMA accept.
m_axis_data  output  DATA_WIDTH  head word.
m_axis_user  output  1  sync flag stored with head word.
level  output  ADDR_WIDTH+1  current word count, 0..DEPTH.

Behaviour:
- Storage: DEPTH x (DATA_WIDTH+1) array; sync bit stored alongside data.
  - Read/write pointers are ADDR_WIDTH+1 bits and wrap naturally.
  - count = wr_ptr - rd_ptr; empty when count==0, full when count==DEPTH.
- Output: first-word-fall-through.
  - m_axis_valid = !empty; m_axis_data/m_axis_user = mem[rd_ptr], combinational read.
  - Pop when valid && ready.
  - Data and user held stable while valid && !ready.
- Latency: a word accepted in cycle N gives valid=1 and is visible at head in cycle N+1 if the FIFO was empty.
- accept = fifo_wr_en && (count<DEPTH || pop) && state-permits. A simultaneous push and pop when full is legal; count is unchanged.
- State machine, 2-bit:
  - IDLE: all writes discarded; pointers forced equal (flush) every cycle. capture_en=1 -> WAIT_SYNC.
  - WAIT_SYNC: writes with sync=0 discarded silently. A write with sync=1 is accepted (FIFO is empty) -> STREAM.
  - STREAM: every write accepted if space. A write with no space is dropped; fifo_wr_overflow pulses next cycle; -> DROP.
  - DROP: FIFO keeps draining. Writes are discarded until a write with sync=1 arrives while space exists; that word is accepted -> STREAM. Discards in DROP do not pulse overflow again.
  - capture_en=0 in any non-IDLE state -> IDLE next cycle. A write in that same cycle is still processed under the current state. Flush occurs in IDLE; any word at the head is lost and valid drops.
- fifo_wr_overflow: registered; high exactly one cycle after the dropping write.
- Reset, with priority over all else:
  - state=IDLE, pointers=0.
  - m_axis_valid=0, fifo_wr_overflow=0, level=0, m_axis_user=0 (masked while empty).
  - Reset mid-stream discards all content.
- fifo_wr_sync without fifo_wr_en is ignored.

Optional Feature:
Macro CPACK_TS_FIFO_DROP_COUNT_EN.
- Defined: adds output drop_count [31:0].
  - Increments once per discarded write in STREAM or DROP; discards in IDLE and WAIT_SYNC are not counted.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by reset and on the cycle the state leaves IDLE.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. Start-on-sync: capture_en=1, writes D0..D2 with sync=0, D3 with sync=1, D4 sync=0, ready=1 -> m_axis emits only D3 (user=1) then D4 (user=0); no overflow.
2. Backpressure fill (ADDR_WIDTH=4): sync write then 16 more writes with ready=0.
   - Required: 16 stored, level=16.
   - 17th write dropped; fifo_wr_overflow high one cycle; state DROP.
3. Resync after overflow: continuing from test 2, ready=1 drains all 16 words in order; writes with sync=0 are discarded; the next sync=1 write is accepted and emitted with user=1; no further overflow pulses.
4. Full push+pop: FIFO at 16, ready=1 and write on the same cycle -> word accepted, level stays 16, no overflow.
5. Mid-stream disable: 5 words buffered, capture_en=0 -> next cycle valid=0, level=0. Re-enable -> waits for sync again.
6. Synchronous reset asserted with 8 words buffered -> next cycle valid=0, level=0, state IDLE; with CPACK_TS_FIFO_DROP_COUNT_EN, drop_count=0.
